// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle for the sequential restoring divider.
// The master issues dividend/divisor with a start pulse; the slave (divider)
// reports busy, a one-cycle done strobe and the held result.
interface seq_restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per
// clock, WIDTH steps per operation, result held until the next accepted start.
// A zero divisor skips iteration and reports all-ones / dividend / flag.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // The partial remainder after a step is always below the divisor, so its
    // top bit is provably zero; only the low WIDTH bits are stored and the
    // extra bit lives in the WIDTH+1-bit trial value.
    logic [WIDTH-1:0] r_reg, r_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   d_ext;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             last_step;

    // One restoring step: shift next dividend bit in, subtract if it fits.
    // When it fits the true difference is below 2^WIDTH, so WIDTH-bit
    // subtraction is exact.
    assign trial     = {r_reg, q_reg[WIDTH-1]};
    assign d_ext     = {1'b0, d_reg};
    assign fits      = (trial >= d_ext);
    assign diff      = trial[WIDTH-1:0] - d_reg;
    assign r_step    = fits ? diff : trial[WIDTH-1:0];
    assign q_step    = {q_reg[WIDTH-2:0], fits};
    assign last_step = (cnt_reg == LAST_STEP);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a zero divisor jumps straight to DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: load on accept, iterate in CALC, publish on the
    // final step so the result is already valid during the DONE cycle.
    always_comb begin
        r_next         = r_reg;
        q_next         = q_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_next  = '1;
                        remainder_next = bus.dividend;
                        dbz_next       = 1'b1;
                    end else begin
                        r_next         = '0;
                        q_next         = bus.dividend;
                        d_next         = bus.divisor;
                        cnt_next       = '0;
                        quotient_next  = '0;
                        remainder_next = '0;
                        dbz_next       = 1'b0;
                    end
                end
            end
            CALC: begin
                r_next   = r_step;
                q_next   = q_step;
                cnt_next = cnt_reg + CW'(1);
                if (last_step) begin
                    quotient_next  = q_step;
                    remainder_next = r_step;
                    dbz_next       = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg         <= '0;
            q_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            r_reg         <= r_next;
            q_reg         <= q_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: stimulus pushes expected
// results (from plain integer division) into a scoreboard, a negedge monitor
// pops and compares whenever done is high.
module tb_seq_restoring_divider;
    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_restoring_divider_if #(.WIDTH(W)) bus();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endfunction

    // Reference: unsigned integer division; zero divisor reports all ones.
    function automatic exp_t model(int a, int b, int due);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.due = due;
        if (b == 0) begin
            e.q   = MAXV;
            e.r   = a;
            e.dbz = 1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 0;
        end
        return e;
    endfunction

    // Monitor: every done cycle must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("txn %0d/%0d -> q=%0d r=%0d dbz=%0d at cycle %0d",
                         e.a, e.b, bus.quotient, bus.remainder, bus.div_by_zero, cyc);
                check("quotient",    int'(bus.quotient),    e.q);
                check("remainder",   int'(bus.remainder),   e.r);
                check("div_by_zero", int'(bus.div_by_zero), e.dbz);
                check("done_cycle",  cyc,                   e.due);
            end
        end
    end

    // Issue one operation, expect done WIDTH cycles later (same cycle for /0),
    // and count busy cycles; inputs are scrambled afterwards to show they
    // are ignored outside the accepting edge.
    task automatic do_op(input int a, input int b);
        int n;
        int busy_cnt;
        int guard;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(b);
        @(posedge clk);
        #1;
        n = cyc;
        sb.push_back(model(a, b, (b == 0) ? n : n + W));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        busy_cnt = 0;
        guard    = 0;
        while (bus.busy && guard < 40) begin
            busy_cnt++;
            guard++;
            @(negedge clk);
        end
        check("busy_cycles", busy_cnt, (b == 0) ? 1 : W + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int guard;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",        int'(bus.busy),        0);
        check("rst_done",        int'(bus.done),        0);
        check("rst_quotient",    int'(bus.quotient),    0);
        check("rst_remainder",   int'(bus.remainder),   0);
        check("rst_div_by_zero", int'(bus.div_by_zero), 0);

        // Directed cases and boundaries
        do_op(13, 3);
        do_op(15, 1);
        do_op(7, 9);
        do_op(15, 15);
        do_op(0, 5);
        do_op(9, 0);
        do_op(8, 2);

        // Start held high; operands change mid-CALC and must not disturb
        // the first result. The second start lands in the IDLE cycle after DONE.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(12);
        bus.divisor  = W'(5);
        @(posedge clk);
        #1;
        n = cyc;
        sb.push_back(model(12, 5, n + W));
        sb.push_back(model(1, 1, n + W + 2 + W));
        repeat (2) @(negedge clk);
        bus.dividend = W'(1);
        bus.divisor  = W'(1);
        while (cyc < n + W + 2) @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy && guard < 40) begin
            guard++;
            @(negedge clk);
        end
        check("held_start_idle", int'(bus.busy), 0);

        // Reset during the second CALC cycle aborts without a done pulse
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = W'(14);
        bus.divisor  = W'(3);
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",        int'(bus.busy),        0);
        check("abort_done",        int'(bus.done),        0);
        check("abort_quotient",    int'(bus.quotient),    0);
        check("abort_remainder",   int'(bus.remainder),   0);
        check("abort_div_by_zero", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        do_op(14, 3);

        // Exhaustive sweep over nonzero divisors
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 1; b <= MAXV; b++) begin
                do_op(a, b);
            end
        end

        // Random operands, zero divisor included
        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(MAXV, 0)), int'($urandom_range(MAXV, 0)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
